// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reset_sequencer_pkg
// Shared definitions for the reset sequencer:
//   - state_e   : sequencer state encoding (IDLE=0, HOLD=1, STG1=2, STG2=3)
//   - CAUSE_*   : bit positions inside the sticky CAUSE register
//   - timer_width() : width of the stage timer for given hold/stagger lengths
// -----------------------------------------------------------------------------
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_STG1 = 2'd2,
        ST_STG2 = 2'd3
    } state_e;

    localparam int CAUSE_WD = 0;
    localparam int CAUSE_SW = 1;

    // clog2(max(hold, stagger)) holds every reload value (hold-1, stagger-1);
    // clamped to one bit so a degenerate 1/1 configuration still elaborates.
    function automatic int timer_width(input int hold, input int stagger);
        int m;
        m = (hold > stagger) ? hold : stagger;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Bundles the request inputs and reset/status outputs of reset_sequencer.
//   WDRST, SWRST  : level reset requests (watchdog RSTOUT, software)
//   CAUSE_CLR     : one-cycle pulse clearing the sticky cause bits
//   SYS_RST, PERIPH_RST, CPU_RST : staged active-high resets
//   BUSY          : sequencer not idle
//   CAUSE         : sticky cause {sw, wd}
//   RST_COUNT     : saturating count of reset sequences
//   STATE         : current sequencer state, for observation only
// Signalling: there is no valid/ready handshake on this bus. Requests are
// plain levels sampled on every rising clock edge; every output is a level
// that is valid after each rising edge and holds until the next one.
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int CNT_W = 8
);
    import reset_sequencer_pkg::*;

    logic             WDRST;
    logic             SWRST;
    logic             CAUSE_CLR;
    logic             SYS_RST;
    logic             PERIPH_RST;
    logic             CPU_RST;
    logic             BUSY;
    logic [1:0]       CAUSE;
    logic [CNT_W-1:0] RST_COUNT;
    state_e           STATE;

    modport master (
        output WDRST, SWRST, CAUSE_CLR,
        input  SYS_RST, PERIPH_RST, CPU_RST, BUSY, CAUSE, RST_COUNT, STATE
    );

    modport slave (
        input  WDRST, SWRST, CAUSE_CLR,
        output SYS_RST, PERIPH_RST, CPU_RST, BUSY, CAUSE, RST_COUNT, STATE
    );

endinterface

// File: rtl/reset_sequencer_rst_stage_timer.sv
// -----------------------------------------------------------------------------
// rst_stage_timer
// Reloadable down-counter used to time the hold and stagger phases.
//   CLK, RST    : clock, synchronous active-high reset (loads RST_VAL)
//   load_i      : load load_val_i (has priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one; holds at zero
//   zero_o      : counter is zero
// -----------------------------------------------------------------------------
module rst_stage_timer #(
    parameter int unsigned   W       = 4,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Turns any reset request (watchdog or software) into a staged reset that
// holds all outputs for HOLD_CYCLES after the last request, then releases
// SYS_RST, PERIPH_RST and CPU_RST in that order, STAGGER_CYCLES apart.
// Also keeps a sticky reset cause and a saturating reset-sequence counter.
//   CLK, RST : clock, synchronous active-high reset (runs a full sequence)
//   bus      : reset_sequencer_if.slave (requests in, resets/status out)
// -----------------------------------------------------------------------------
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic              CLK,
    input  logic              RST,
    reset_sequencer_if.slave  bus
);

    localparam int            TW      = timer_width(HOLD_CYCLES, STAGGER_CYCLES);
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] STAG_LD = TW'(STAGGER_CYCLES - 1);

    state_e           state_q;
    logic             sys_q, periph_q, cpu_q;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             req;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]    tmr_val;

    assign req = bus.WDRST | bus.SWRST;

    // Saturating increment, only committed on entry to HOLD.
    assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // A set on the same edge as CAUSE_CLR wins for that bit.
    always_comb begin
        cause_d = bus.CAUSE_CLR ? 2'b00 : cause_q;
        if (bus.WDRST) cause_d[CAUSE_WD] = 1'b1;
        if (bus.SWRST) cause_d[CAUSE_SW] = 1'b1;
    end

    // Timer control: any request reloads the hold length; a phase that
    // expires loads the stagger length for the next phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HOLD_LD;
        tmr_dec  = 1'b0;
        if (req) begin
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD, ST_STG1: begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = STAG_LD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_STG2: tmr_dec = !tmr_zero;
                default: ;
            endcase
        end
    end

    rst_stage_timer #(
        .W       (TW),
        .RST_VAL (HOLD_LD)
    ) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_HOLD;
            sys_q    <= 1'b1;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
            cause_q  <= 2'b00;
            cnt_q    <= '0;
        end else begin
            cause_q <= cause_d;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q  <= ST_HOLD;
                        sys_q    <= 1'b1;
                        periph_q <= 1'b1;
                        cpu_q    <= 1'b1;
                        cnt_q    <= cnt_d;
                    end
                end
                ST_HOLD: begin
                    // A held request keeps reloading the timer, so HOLD lasts
                    // as long as the request plus HOLD_CYCLES.
                    if (!req && tmr_zero) begin
                        state_q <= ST_STG1;
                        sys_q   <= 1'b0;
                    end
                end
                ST_STG1: begin
                    if (req) begin
                        state_q <= ST_HOLD;
                        sys_q   <= 1'b1;
                        cnt_q   <= cnt_d;
                    end else if (tmr_zero) begin
                        state_q  <= ST_STG2;
                        periph_q <= 1'b0;
                    end
                end
                ST_STG2: begin
                    if (req) begin
                        state_q  <= ST_HOLD;
                        sys_q    <= 1'b1;
                        periph_q <= 1'b1;
                        cnt_q    <= cnt_d;
                    end else if (tmr_zero) begin
                        state_q <= ST_IDLE;
                        cpu_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.SYS_RST    = sys_q;
    assign bus.PERIPH_RST = periph_q;
    assign bus.CPU_RST    = cpu_q;
    assign bus.BUSY       = (state_q != ST_IDLE);
    assign bus.CAUSE      = cause_q;
    assign bus.RST_COUNT  = cnt_q;
    assign bus.STATE      = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Two sequencers share one stimulus: dut_a with an 8-bit event counter and
// dut_b with a 2-bit counter, so the same run shows counting and saturation.
// Each expected vector is {SYS,PERIPH,CPU,BUSY, CAUSE, count_a, count_b}.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    logic CLK = 1'b0;
    logic RST;
    logic wdrst, swrst, cause_clr;

    always #5 CLK = ~CLK;

    reset_sequencer_if #(.CNT_W(8)) bus_a ();
    reset_sequencer_if #(.CNT_W(2)) bus_b ();

    assign bus_a.WDRST     = wdrst;
    assign bus_a.SWRST     = swrst;
    assign bus_a.CAUSE_CLR = cause_clr;
    assign bus_b.WDRST     = wdrst;
    assign bus_b.SWRST     = swrst;
    assign bus_b.CAUSE_CLR = cause_clr;

    reset_sequencer #(.HOLD_CYCLES(16), .STAGGER_CYCLES(4), .CNT_W(8)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a)
    );

    reset_sequencer #(.HOLD_CYCLES(16), .STAGGER_CYCLES(4), .CNT_W(2)) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b)
    );

    logic [15:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [15:0] pack_exp(input logic [3:0] rb,
                                             input logic [1:0] cause,
                                             input int cnt);
        int sat;
        sat = (cnt > 3) ? 3 : cnt;
        return {rb, cause, 8'(cnt), 2'(sat)};
    endfunction

    // Push the expected vector for the coming edge, let the edge happen,
    // then pop and compare one time unit later.
    task automatic tick(input string tag, input logic [3:0] rb,
                        input logic [1:0] cause, input int cnt);
        logic [15:0] got, exp;
        logic        inv;
        exp_q.push_back(pack_exp(rb, cause, cnt));
        @(posedge CLK);
        #1;
        exp = exp_q.pop_front();
        got = {bus_a.SYS_RST, bus_a.PERIPH_RST, bus_a.CPU_RST, bus_a.BUSY,
               bus_a.CAUSE, bus_a.RST_COUNT, bus_b.RST_COUNT};
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
        inv = (bus_a.CPU_RST  | !bus_a.PERIPH_RST) & (bus_a.PERIPH_RST | !bus_a.SYS_RST) &
              (bus_b.CPU_RST  | !bus_b.PERIPH_RST) & (bus_b.PERIPH_RST | !bus_b.SYS_RST);
        n_vec++;
        assert (inv === 1'b1) else begin
            n_bad++;
            $error("FAIL %s_order: observed=%b expected=1", tag, inv);
        end
    endtask

    // Expected release after the edge that sampled the last request:
    // 15 more edges fully in reset, SYS drops on edge 16, PERIPH on 20,
    // CPU and BUSY on 24.
    task automatic release_seq(input string tag, input logic [1:0] cause, input int cnt);
        repeat (15) tick(tag, 4'b1111, cause, cnt);
        repeat (4)  tick(tag, 4'b0111, cause, cnt);
        repeat (4)  tick(tag, 4'b0011, cause, cnt);
        tick(tag, 4'b0000, cause, cnt);
        repeat (2)  tick(tag, 4'b0000, cause, cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; wdrst = 1'b0; swrst = 1'b0; cause_clr = 1'b0;

        // Power-up: sequence runs from the last RST edge
        repeat (3) tick("por_rst", 4'b1111, 2'b00, 0);
        RST = 1'b0;
        release_seq("por", 2'b00, 0);

        // Single watchdog pulse
        wdrst = 1'b1;
        tick("wd_pulse_on", 4'b1111, 2'b01, 1);
        wdrst = 1'b0;
        release_seq("wd_pulse", 2'b01, 1);

        // Held watchdog: one count, hold stretches
        wdrst = 1'b1;
        repeat (40) tick("wd_held_on", 4'b1111, 2'b01, 2);
        wdrst = 1'b0;
        release_seq("wd_held", 2'b01, 2);

        // Software request two cycles after PERIPH release (in STG2)
        wdrst = 1'b1;
        tick("stg2_wd_on", 4'b1111, 2'b01, 3);
        wdrst = 1'b0;
        repeat (15) tick("stg2_hold", 4'b1111, 2'b01, 3);
        repeat (4)  tick("stg2_s1", 4'b0111, 2'b01, 3);
        repeat (2)  tick("stg2_s2", 4'b0011, 2'b01, 3);
        swrst = 1'b1;
        tick("stg2_sw_on", 4'b1111, 2'b11, 4);
        swrst = 1'b0;
        release_seq("stg2_rel", 2'b11, 4);

        // Cause clear alone, then clear colliding with a software set
        cause_clr = 1'b1;
        tick("clr_only", 4'b0000, 2'b00, 4);
        cause_clr = 1'b0;
        wdrst = 1'b1;
        tick("clr_wd_on", 4'b1111, 2'b01, 5);
        wdrst = 1'b0;
        release_seq("clr_wd", 2'b01, 5);
        cause_clr = 1'b1; swrst = 1'b1;
        tick("clr_sw_on", 4'b1111, 2'b10, 6);
        cause_clr = 1'b0; swrst = 1'b0;
        release_seq("clr_sw", 2'b10, 6);

        // Both requests on the same edge
        wdrst = 1'b1; swrst = 1'b1;
        tick("both_on", 4'b1111, 2'b11, 7);
        wdrst = 1'b0; swrst = 1'b0;
        release_seq("both", 2'b11, 7);

        // Re-request in STG1 reasserts only SYS_RST
        cause_clr = 1'b1;
        tick("clr_idle", 4'b0000, 2'b00, 7);
        cause_clr = 1'b0;
        wdrst = 1'b1;
        tick("stg1_wd_on", 4'b1111, 2'b01, 8);
        wdrst = 1'b0;
        repeat (15) tick("stg1_hold", 4'b1111, 2'b01, 8);
        repeat (2)  tick("stg1_s1", 4'b0111, 2'b01, 8);
        swrst = 1'b1;
        tick("stg1_sw_on", 4'b1111, 2'b11, 9);
        swrst = 1'b0;
        release_seq("stg1_rel", 2'b11, 9);

        // RST mid-sequence discards everything and restarts the sequence
        wdrst = 1'b1;
        tick("mid_wd_on", 4'b1111, 2'b11, 10);
        wdrst = 1'b0;
        repeat (15) tick("mid_hold", 4'b1111, 2'b11, 10);
        tick("mid_s1", 4'b0111, 2'b11, 10);
        RST = 1'b1;
        tick("mid_rst", 4'b1111, 2'b00, 0);
        RST = 1'b0;
        release_seq("mid_rel", 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
